// File: rtl/i2c_pkg.sv
// Shared types and constants for the three-requester I2C master arbiter.
package i2c_pkg;

    localparam int unsigned NREQ_DEF    = 3;
    localparam int unsigned TIMEOUT_DEF = 65535;
    localparam int unsigned NB_W        = 2;
    localparam int unsigned RP_W        = 8;
    localparam int unsigned DEV_W       = 7;
    localparam int unsigned DAT_W       = 8;
    localparam int unsigned CNT_W       = 16;

    typedef enum logic [1:0] {
        S_IDLE,
        S_LAUNCH,
        S_BUSY,
        S_RELEASE
    } arb_state_e;

    function automatic logic [1:0] onehot_to_idx(input logic [2:0] oh);
        case (oh)
            3'b010:  return 2'd1;
            3'b100:  return 2'd2;
            default: return 2'd0;
        endcase
    endfunction

endpackage

// File: rtl/i2c_arbiter_if.sv
// Requester-side and master-side signals of the arbiter; "master" is the arbiter's own view.
interface i2c_arbiter_if;
    import i2c_pkg::*;

    logic [NREQ_DEF-1:0]       req;
    logic [NREQ_DEF-1:0]       req_rw;
    logic [NREQ_DEF*NB_W-1:0]  req_nbyte;
    logic [NREQ_DEF*RP_W-1:0]  req_rptr;
    logic [NREQ_DEF*DEV_W-1:0] req_dev;
    logic [NREQ_DEF*DAT_W-1:0] req_dwr;
    logic [NREQ_DEF-1:0]       grant;
    logic [NREQ_DEF-1:0]       gnt_ready;
    logic [NREQ_DEF-1:0]       gnt_done;
    logic [NREQ_DEF-1:0]       gnt_err;
    logic [DAT_W-1:0]          drd;
    logic                      go;
    logic                      rw;
    logic [NB_W-1:0]           N_byte;
    logic [RP_W-1:0]           R_Pointer;
    logic [DEV_W-1:0]          dev_add;
    logic [DAT_W-1:0]          dwr;
    logic                      ready;
    logic                      done;
    logic [DAT_W-1:0]          m_drd;

    modport master (
        input  req, req_rw, req_nbyte, req_rptr, req_dev, req_dwr,
        input  ready, done, m_drd,
        output grant, gnt_ready, gnt_done, gnt_err, drd,
        output go, rw, N_byte, R_Pointer, dev_add, dwr
    );

    modport slave (
        output req, req_rw, req_nbyte, req_rptr, req_dev, req_dwr,
        output ready, done, m_drd,
        input  grant, gnt_ready, gnt_done, gnt_err, drd,
        input  go, rw, N_byte, R_Pointer, dev_add, dwr
    );

endinterface

// File: rtl/rr_pick3.sv
// Combinational round-robin pick among three requests; priority starts just after last.
module rr_pick3 (
    input  logic [2:0] req_i,
    input  logic [1:0] last_i,
    output logic [2:0] win_o,
    output logic       valid_o
);

    always_comb begin
        win_o = '0;
        case (last_i)
            2'd0: begin
                if (req_i[1])      win_o = 3'b010;
                else if (req_i[2]) win_o = 3'b100;
                else if (req_i[0]) win_o = 3'b001;
            end
            2'd1: begin
                if (req_i[2])      win_o = 3'b100;
                else if (req_i[0]) win_o = 3'b001;
                else if (req_i[1]) win_o = 3'b010;
            end
            default: begin
                if (req_i[0])      win_o = 3'b001;
                else if (req_i[1]) win_o = 3'b010;
                else if (req_i[2]) win_o = 3'b100;
            end
        endcase
    end

    assign valid_o = |req_i;

endmodule

// File: rtl/i2c_arbiter.sv
// Shares one I2C master between three requesters: round-robin grant, one-cycle go,
// status routed to the owner only, and a saturating timeout that forces release.
module i2c_arbiter
    import i2c_pkg::*;
#(
    parameter int unsigned NREQ    = NREQ_DEF,
    parameter int unsigned TIMEOUT = TIMEOUT_DEF
) (
    input logic           clk,
    input logic           reset,
    i2c_arbiter_if.master bus
);

    localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TIMEOUT - 1);

    arb_state_e        state_q, state_d;
    logic [NREQ-1:0]   grant_q, grant_d;
    logic [NREQ-1:0]   err_q, err_d;
    logic [1:0]        last_q, last_d;
    logic              go_q, go_d;
    logic              rw_q, rw_d;
    logic [NB_W-1:0]   nbyte_q, nbyte_d;
    logic [RP_W-1:0]   rptr_q, rptr_d;
    logic [DEV_W-1:0]  dev_q, dev_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;

    logic [2:0]        win;
    logic              win_valid;
    logic              sel_rw;
    logic [NB_W-1:0]   sel_nbyte;
    logic [RP_W-1:0]   sel_rptr;
    logic [DEV_W-1:0]  sel_dev;

    rr_pick3 u_pick (
        .req_i   (bus.req),
        .last_i  (last_q),
        .win_o   (win),
        .valid_o (win_valid)
    );

    always_comb begin
        case (onehot_to_idx(win))
            2'd1: begin
                sel_rw    = bus.req_rw[1];
                sel_nbyte = bus.req_nbyte[3:2];
                sel_rptr  = bus.req_rptr[15:8];
                sel_dev   = bus.req_dev[13:7];
            end
            2'd2: begin
                sel_rw    = bus.req_rw[2];
                sel_nbyte = bus.req_nbyte[5:4];
                sel_rptr  = bus.req_rptr[23:16];
                sel_dev   = bus.req_dev[20:14];
            end
            default: begin
                sel_rw    = bus.req_rw[0];
                sel_nbyte = bus.req_nbyte[1:0];
                sel_rptr  = bus.req_rptr[7:0];
                sel_dev   = bus.req_dev[6:0];
            end
        endcase
    end

    // Grant is dropped on the BUSY exit edge so the RELEASE cycle already shows it idle.
    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        err_d   = '0;
        last_d  = last_q;
        go_d    = 1'b0;
        rw_d    = rw_q;
        nbyte_d = nbyte_q;
        rptr_d  = rptr_q;
        dev_d   = dev_q;
        cnt_d   = cnt_q;
        case (state_q)
            S_IDLE: begin
                if (win_valid) begin
                    grant_d = win;
                    rw_d    = sel_rw;
                    nbyte_d = sel_nbyte;
                    rptr_d  = sel_rptr;
                    dev_d   = sel_dev;
                    state_d = S_LAUNCH;
                end
            end
            S_LAUNCH: begin
                go_d    = 1'b1;
                cnt_d   = '0;
                state_d = S_BUSY;
            end
            S_BUSY: begin
                if (cnt_q != '1) cnt_d = cnt_q + 1'b1;
                if (bus.done || cnt_q == TO_LAST) begin
                    if (!bus.done) err_d = grant_q;
                    last_d  = onehot_to_idx(grant_q);
                    grant_d = '0;
                    state_d = S_RELEASE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            grant_q <= '0;
            err_q   <= '0;
            last_q  <= 2'd2;
            go_q    <= 1'b0;
            rw_q    <= 1'b0;
            nbyte_q <= '0;
            rptr_q  <= '0;
            dev_q   <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            err_q   <= err_d;
            last_q  <= last_d;
            go_q    <= go_d;
            rw_q    <= rw_d;
            nbyte_q <= nbyte_d;
            rptr_q  <= rptr_d;
            dev_q   <= dev_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        bus.dwr = '0;
        if (grant_q[0])      bus.dwr = bus.req_dwr[7:0];
        else if (grant_q[1]) bus.dwr = bus.req_dwr[15:8];
        else if (grant_q[2]) bus.dwr = bus.req_dwr[23:16];
    end

    assign bus.grant     = grant_q;
    assign bus.gnt_ready = (state_q == S_BUSY) ? (grant_q & {NREQ{bus.ready}}) : '0;
    assign bus.gnt_done  = (state_q == S_BUSY) ? (grant_q & {NREQ{bus.done}})  : '0;
    assign bus.gnt_err   = err_q;
    assign bus.drd       = bus.m_drd;
    assign bus.go        = go_q;
    assign bus.rw        = rw_q;
    assign bus.N_byte    = nbyte_q;
    assign bus.R_Pointer = rptr_q;
    assign bus.dev_add   = dev_q;

endmodule

// File: tb/tb_i2c_arbiter.sv
// Directed bench for i2c_arbiter with a short timeout; the master side is driven by hand.
module tb_i2c_arbiter;

    logic clk = 1'b0;
    logic reset;
    int   errors = 0;
    int   checks = 0;

    i2c_arbiter_if bus ();

    i2c_arbiter #(.TIMEOUT(16)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        reset         = 1'b1;
        bus.req       = '0;
        bus.req_rw    = '0;
        bus.req_nbyte = '0;
        bus.req_rptr  = '0;
        bus.req_dev   = '0;
        bus.req_dwr   = '0;
        bus.ready     = 1'b0;
        bus.done      = 1'b0;
        bus.m_drd     = 8'h5A;
        step();
        step();
        chk("rst_grant", 32'(bus.grant), 0);
        chk("rst_go", 32'(bus.go), 0);
        chk("rst_fields", {bus.rw, bus.N_byte, bus.R_Pointer, bus.dev_add}, 0);
        chk("rst_gnt_err", 32'(bus.gnt_err), 0);
        reset = 1'b0;
        step();
        chk("drd_bcast", 32'(bus.drd), 32'h5A);
        bus.ready = 1'b1;
        #1;
        chk("idle_ready_ignored", 32'(bus.gnt_ready), 0);
        bus.ready = 1'b0;

        // Requester 0 read, 2 bytes, dev 0x48, ptr 0x00
        bus.req              = 3'b001;
        bus.req_rw           = 3'b001;
        bus.req_nbyte        = 6'b00_00_10;
        bus.req_rptr         = 24'h33_22_00;
        bus.req_dev          = {7'h3C, 7'h22, 7'h48};
        step();
        chk("t1_grant", 32'(bus.grant), 32'b001);
        chk("t1_go_launch", 32'(bus.go), 0);
        bus.done = 1'b1;
        #1;
        chk("t1_launch_done_ignored", 32'(bus.gnt_done), 0);
        step();
        bus.done = 1'b0;
        chk("t1_go", 32'(bus.go), 1);
        chk("t1_still_granted", 32'(bus.grant), 32'b001);
        chk("t1_fields", {bus.rw, bus.N_byte, bus.R_Pointer, bus.dev_add}, {15'd0, 1'b1, 2'd2, 8'h00, 7'h48});
        bus.req_dev[6:0] = 7'h11;
        bus.req_rw       = 3'b000;
        step();
        chk("t1_go_one_cycle", 32'(bus.go), 0);
        chk("t1_fields_stable", {bus.rw, bus.dev_add}, {24'd0, 1'b1, 7'h48});
        bus.ready = 1'b1;
        #1;
        chk("t1_ready1", 32'(bus.gnt_ready), 32'b001);
        step();
        bus.ready = 1'b0;
        #1;
        chk("t1_ready_low", 32'(bus.gnt_ready), 0);
        bus.ready = 1'b1;
        #1;
        chk("t1_ready2", 32'(bus.gnt_ready), 32'b001);
        step();
        bus.ready = 1'b0;
        bus.done  = 1'b1;
        #1;
        chk("t1_done", 32'(bus.gnt_done), 32'b001);
        step();
        bus.done = 1'b0;
        bus.req  = '0;
        chk("t1_release_grant", 32'(bus.grant), 0);
        chk("t1_release_done", 32'(bus.gnt_done), 0);
        step();

        // Requester 1 write, data byte changes after the first ready
        bus.req               = 3'b010;
        bus.req_nbyte         = 6'b00_10_00;
        bus.req_dwr           = 24'h00_60_00;
        step();
        chk("t2_grant", 32'(bus.grant), 32'b010);
        step();
        chk("t2_go", 32'(bus.go), 1);
        chk("t2_fields", {bus.rw, bus.N_byte, bus.R_Pointer, bus.dev_add}, {15'd0, 1'b0, 2'd2, 8'h22, 7'h22});
        chk("t2_dwr0", 32'(bus.dwr), 32'h60);
        bus.ready = 1'b1;
        #1;
        chk("t2_ready1", 32'(bus.gnt_ready), 32'b010);
        step();
        bus.ready          = 1'b0;
        bus.req_dwr[15:8]  = 8'hA0;
        #1;
        chk("t2_dwr1", 32'(bus.dwr), 32'hA0);
        bus.done = 1'b1;
        #1;
        chk("t2_done", 32'(bus.gnt_done), 32'b010);
        step();
        bus.done = 1'b0;
        bus.req  = '0;
        chk("t2_release", 32'(bus.grant), 0);
        step();

        // Requester 0 drops req mid-transaction; transaction still completes
        bus.req = 3'b001;
        step();
        chk("t3_grant", 32'(bus.grant), 32'b001);
        step();
        bus.req = '0;
        step();
        step();
        chk("t3_hold_after_drop", 32'(bus.grant), 32'b001);
        bus.done = 1'b1;
        #1;
        chk("t3_done", 32'(bus.gnt_done), 32'b001);
        step();
        bus.done = 1'b0;
        step();
        step();
        chk("t3_idle_no_regrant", 32'(bus.grant), 0);

        // Reset in BUSY, then rotation with all three requesting
        bus.req = 3'b111;
        step();
        chk("t4_grant_pre_reset", 32'(bus.grant), 32'b010);
        step();
        step();
        reset = 1'b1;
        step();
        reset = 1'b0;
        chk("t4_rst_grant", 32'(bus.grant), 0);
        chk("t4_rst_go", 32'(bus.go), 0);
        step();
        chk("t4_rr0", 32'(bus.grant), 32'b001);
        step();
        bus.done = 1'b1;
        step();
        bus.done = 1'b0;
        step();
        step();
        chk("t4_rr1", 32'(bus.grant), 32'b010);
        step();
        bus.done = 1'b1;
        step();
        bus.done = 1'b0;
        step();
        step();
        chk("t4_rr2", 32'(bus.grant), 32'b100);
        step();
        bus.done = 1'b1;
        step();
        bus.done = 1'b0;
        step();
        step();
        chk("t4_rr3", 32'(bus.grant), 32'b001);

        // No done from the master: forced release 16 cycles after go
        step();
        chk("t5_go", 32'(bus.go), 1);
        for (int unsigned k = 0; k < 15; k++) step();
        chk("t5_no_err_yet", 32'(bus.gnt_err), 0);
        chk("t5_still_granted", 32'(bus.grant), 32'b001);
        step();
        chk("t5_err", 32'(bus.gnt_err), 32'b001);
        chk("t5_released", 32'(bus.grant), 0);
        step();
        chk("t5_err_pulse", 32'(bus.gnt_err), 0);
        step();
        chk("t5_next_grant", 32'(bus.grant), 32'b010);
        bus.req = '0;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/i2c_arbiter.md
I2C_ARBITER -- requirements
Module: i2c_arbiter

Interface
REQ-001 Parameter NREQ, 3, number of requesters sharing the I2C master (fixed 3 for this release).
REQ-002 Parameter TIMEOUT, 65535, cycles allowed from go to done before forced release.
REQ-003 Clock and reset: one clock, clk; reset is synchronous and active-high, named reset.
REQ-004 clk  in  1  system clock, all logic on rising edge.
REQ-005 reset  in  1  synchronous active-high reset.
REQ-006 req  in  3  per-requester request, held high until that requester's gnt_done.
REQ-007 req_rw  in  3  per-requester read(1)/write(0).
REQ-008 req_nbyte  in  6  per-requester byte count, 2 bits each, requester i at [2i+1:2i].
REQ-009 req_rptr  in  24  per-requester register pointer, 8 bits each.
REQ-010 req_dev  in  21  per-requester 7-bit device address.
REQ-011 req_dwr  in  24  per-requester write data byte, 8 bits each.
REQ-012 grant  out  3  one-hot owner of the master; all-zero when idle.
REQ-013 gnt_ready  out  3  master ready routed to owner only.
REQ-014 gnt_done  out  3  master done routed to owner only, one-cycle pulse.
REQ-015 gnt_err  out  3  one-cycle timeout pulse to owner.
REQ-016 drd  out  8  master read byte, broadcast unmodified.
REQ-017 go, rw, N_byte[1:0], R_Pointer[7:0], dev_add[6:0], dwr[7:0]  out  master command bus.
REQ-018 ready, done  in  1 each; m_drd  in  8; master status and read data.

Function
REQ-019 FSM states SHALL be IDLE, LAUNCH, BUSY, RELEASE.
REQ-020 IDLE: if any req bit high, winner chosen round-robin starting at (last+1) mod 3; grant, rw, N_byte, R_Pointer, dev_add registered from winner; next LAUNCH. No req: stay IDLE.
REQ-021 LAUNCH: go=1 for exactly one cycle; timeout counter cleared; next BUSY.
REQ-022 BUSY: dwr follows owner's req_dwr combinationally so a requester may change byte after each ready; ready and done routed to owner's gnt_ready/gnt_done, zero to others.
REQ-023 BUSY exit on done=1 -> RELEASE; counter reaching TIMEOUT-1 without done -> gnt_err pulse to owner, RELEASE.
REQ-024 RELEASE: grant=0, last<=owner index, next IDLE; earliest regrant is therefore 2 cycles after done.
REQ-025 Latency: req high in IDLE -> grant next cycle -> go the cycle after.
REQ-026 Simultaneous requests: rotation guarantees each requester served within 3 transactions; after reset last=2 so requester 0 wins first.
REQ-027 req dropped during LAUNCH/BUSY SHALL NOT abort; transaction completes, done still routed.
REQ-028 done received in LAUNCH SHALL be ignored; ready/done in IDLE or RELEASE ignored.
REQ-029 Command fields SHALL stay stable from LAUNCH through BUSY regardless of requester input changes (except dwr per REQ-022).
REQ-030 Timeout counter 16 bits, saturating, never wraps.

Reset
REQ-031 reset SHALL force IDLE, last=2, grant=0, go=0, rw=0, N_byte=0, R_Pointer=0, dev_add=0, counter=0, gnt_* =0, including mid-transaction; the master is reset by the same signal.

Structure
REQ-032 State encoding, NREQ, TIMEOUT default and field widths (2/8/7/8) SHALL live in shared package i2c_pkg.
REQ-033 Round-robin priority selector SHALL be a sub-module rr_pick3 (req, last -> one-hot winner, valid), purely combinational.

Verification
REQ-034 Single req=3'b001, rw=1, N_byte=2, R_Pointer=8'h00, dev_add=7'h48 -> grant=001 at T+1, one go pulse at T+2 with those fields, two gnt_ready[0] pulses, gnt_done[0], grant=0 at done+1.
REQ-035 req=3'b111 held continuously -> grant sequence 001,010,100,001; no two consecutive grants to same requester.
REQ-036 Requester 1 write N_byte=2, req_dwr[15:8] changes 8'h60->8'hA0 after first ready -> master sees dwr 8'h60 then 8'hA0.
REQ-037 Master never asserts done, TIMEOUT=16 -> gnt_err[owner] pulse 16 cycles after go, grant released, next requester granted.
REQ-038 reset asserted in BUSY -> next cycle grant=0, go=0, state IDLE; first grant after reset goes to requester 0 with req=3'b111.
REQ-039 req[0] dropped in BUSY -> transaction completes, gnt_done[0] pulses, arbiter returns to IDLE.
